// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-address stack block:
// op encoding, strobe priority encoder, default widths and SP width helper.
package pc_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_INR,
    OP_LD,
    OP_RET,
    OP_CALL,
    OP_CLR
  } op_e;

  // Reset is handled by the registers themselves; this only ranks CLR > CALL > RET > LD > INR.
  function automatic op_e op_select(input logic clr, input logic call, input logic ret,
                                    input logic ld, input logic inr);
    op_e op;
    op = OP_NONE;
    if (clr)       op = OP_CLR;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (ld)   op = OP_LD;
    else if (inr)  op = OP_INR;
    return op;
  endfunction

  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_program_counter_stack_ras.sv
// Return-address stack: DEPTH-entry register file with write pointer and count.
// Saturates with a sticky overflow flag unless PC_STACK_WRAP_EN makes it circular.
module ras_return_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [ADDR_W-1:0]         push_data_i,
  output logic [ADDR_W-1:0]         top_data_o,
  output logic [$clog2(DEPTH):0]    depth_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = sp_width(DEPTH);
  localparam logic [SW-1:0] FULL_CNT = SW'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [IW-1:0]     wr_q;
  logic [SW-1:0]     cnt_q;
  logic              ovf_q, udf_q;
  logic              full, empty, do_write;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // The write pointer wraps naturally, so a circular overwrite lands on the oldest slot.
`ifdef PC_STACK_WRAP_EN
  assign do_write = push_i;
`else
  assign do_write = push_i && !full;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (push_i) begin
      if (do_write) begin
        wr_q <= wr_q + 1'b1;
        if (!full) cnt_q <= cnt_q + 1'b1;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (pop_i) begin
      if (empty) begin
        udf_q <= 1'b1;
      end else begin
        wr_q  <= wr_q - 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_write) mem_q[wr_q] <= push_data_i;
  end

  assign top_data_o  = mem_q[wr_q - 1'b1];
  assign depth_o     = cnt_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: rtl/pc_program_counter_stack.sv
// Program counter with load/increment/clear plus hardware CALL/RET return stack.
// Optional macro PC_STACK_WRAP_EN selects a circular (non-saturating) return stack.
module pc_program_counter_stack
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                DEPTH        = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk_clock,
  input  logic                   RST_reset,
  input  logic                   CLR_clear,
  input  logic                   LD_load,
  input  logic                   INR_increment,
  input  logic                   CALL_call,
  input  logic                   RET_return,
  input  logic [ADDR_W-1:0]      PC_input,
  output logic [ADDR_W-1:0]      PC_output,
  output logic [$clog2(DEPTH):0] SP_depth,
  output logic                   STK_full,
  output logic                   STK_empty,
  output logic                   WRAP_pulse,
  output logic                   ERR_overflow,
  output logic                   ERR_underflow
);

  op_e               op;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top_data;
  logic              wrap_q, wrap_d;
  logic              stk_empty;

  assign op     = op_select(CLR_clear, CALL_call, RET_return, LD_load, INR_increment);
  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    case (op)
      OP_CLR:  pc_d = RESET_VECTOR;
      OP_CALL: pc_d = PC_input;
      OP_RET:  if (!stk_empty) pc_d = top_data;
      OP_LD:   pc_d = PC_input;
      OP_INR: begin
        pc_d   = pc_inc;
        wrap_d = (pc_q == '1);
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_clock) begin
    if (RST_reset) begin
      pc_q   <= RESET_VECTOR;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  ras_return_stack #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk_i      (clk_clock),
    .rst_i      (RST_reset),
    .push_i     (op == OP_CALL),
    .pop_i      (op == OP_RET),
    .push_data_i(pc_inc),
    .top_data_o (top_data),
    .depth_o    (SP_depth),
    .full_o     (STK_full),
    .empty_o    (stk_empty),
    .overflow_o (ERR_overflow),
    .underflow_o(ERR_underflow)
  );

  assign STK_empty  = stk_empty;
  assign PC_output  = pc_q;
  assign WRAP_pulse = wrap_q;

endmodule

// File: tb/tb_pc_program_counter_stack.sv
// Bench for pc_program_counter_stack: directed scenarios plus randomized strobes
// checked against a queue-based behavioural model of PC and return stack.
module tb_pc_program_counter_stack;

  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 4;
  localparam logic [3:0]  RV     = 4'd0;
  localparam int          MODV   = 1 << ADDR_W;

  logic             clk = 1'b0;
  logic             rst, clr, ld, inr, call, ret;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc_out;
  logic [$clog2(DEPTH):0] sp;
  logic             full, empty, wrap, ovf, udf;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_pc;
  int m_stk[$];
  bit m_wrap, m_ovf, m_udf;

  always #5 clk = ~clk;

  pc_program_counter_stack #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .clk_clock(clk), .RST_reset(rst), .CLR_clear(clr), .LD_load(ld),
    .INR_increment(inr), .CALL_call(call), .RET_return(ret), .PC_input(pc_in),
    .PC_output(pc_out), .SP_depth(sp), .STK_full(full), .STK_empty(empty),
    .WRAP_pulse(wrap), .ERR_overflow(ovf), .ERR_underflow(udf)
  );

  // Driver: apply one cycle of strobes, advance the model, sample 1ns after the edge.
  task automatic step(input bit r, input bit c, input bit l, input bit i,
                      input bit ca, input bit re, input int din);
    rst = r; clr = c; ld = l; inr = i; call = ca; ret = re; pc_in = ADDR_W'(din);
    @(posedge clk);
    if (r) begin
      m_pc = RV; m_stk.delete(); m_wrap = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_wrap = 0;
      if (c) m_pc = RV;
      else if (ca) begin
        if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MODV);
        else begin
`ifdef PC_STACK_WRAP_EN
          void'(m_stk.pop_front());
          m_stk.push_back((m_pc + 1) % MODV);
`else
          m_ovf = 1;
`endif
        end
        m_pc = din % MODV;
      end else if (re) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else m_udf = 1;
      end else if (l) m_pc = din % MODV;
      else if (i) begin
        m_wrap = (m_pc == MODV - 1);
        m_pc   = (m_pc + 1) % MODV;
      end
    end
    #1;
    rst = 0; clr = 0; ld = 0; inr = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 0);
    total++; if (pc_out !== RV) begin bad++; $display("FAIL reset_pc got=%0d exp=%0d", pc_out, RV); end
    total++; if (sp !== 0) begin bad++; $display("FAIL reset_sp got=%0d exp=0", sp); end
    total++; if ({empty, full, wrap, ovf, udf} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, wrap, ovf, udf});
    end
  endtask

  task automatic test_inr_wrap;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      total++; if (pc_out !== ADDR_W'(k)) begin bad++; $display("FAIL inr_pc got=%0d exp=%0d", pc_out, k); end
    end
    step(0, 0, 1, 0, 0, 0, 15);
    step(0, 0, 0, 1, 0, 0, 0);
    total++; if (pc_out !== 4'd0 || wrap !== 1'b1) begin
      bad++; $display("FAIL inr_wrap got pc=%0d wrap=%b exp pc=0 wrap=1", pc_out, wrap);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_pulse_len got=%b exp=0", wrap); end
    step(0, 0, 0, 1, 0, 0, 0);
    total++; if (wrap !== 1'b0 || pc_out !== 4'd1) begin
      bad++; $display("FAIL inr_nowrap got pc=%0d wrap=%b exp pc=1 wrap=0", pc_out, wrap);
    end
  endtask

  task automatic test_call_ret;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 5);
    step(0, 0, 0, 0, 1, 0, 9);
    total++; if (pc_out !== 4'd9 || sp !== 1) begin
      bad++; $display("FAIL call got pc=%0d sp=%0d exp pc=9 sp=1", pc_out, sp);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if (pc_out !== 4'd6 || sp !== 0 || empty !== 1'b1) begin
      bad++; $display("FAIL ret got pc=%0d sp=%0d empty=%b exp pc=6 sp=0 empty=1", pc_out, sp, empty);
    end
  endtask

  task automatic test_overflow;
    int exp_ret[4];
    step(1, 0, 0, 0, 0, 0, 0);
    // Each call targets k, so pushes are 1,2,3,4,5 in order.
    for (int k = 1; k <= 5; k++) step(0, 0, 0, 0, 1, 0, k);
    total++; if (sp !== DEPTH || full !== 1'b1) begin
      bad++; $display("FAIL ovf_depth got sp=%0d full=%b exp sp=%0d full=1", sp, full, DEPTH);
    end
`ifdef PC_STACK_WRAP_EN
    exp_ret = '{5, 4, 3, 2};
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_flag got=%b exp=0", ovf); end
`else
    exp_ret = '{4, 3, 2, 1};
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      total++; if (pc_out !== ADDR_W'(exp_ret[k])) begin
        bad++; $display("FAIL ovf_ret%0d got=%0d exp=%0d", k, pc_out, exp_ret[k]);
      end
    end
    total++; if (empty !== 1'b1 || udf !== 1'b0) begin
      bad++; $display("FAIL ovf_drain got empty=%b udf=%b exp empty=1 udf=0", empty, udf);
    end
  endtask

  task automatic test_underflow;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if (pc_out !== 4'd7 || udf !== 1'b1 || sp !== 0) begin
      bad++; $display("FAIL udf got pc=%0d udf=%b sp=%0d exp pc=7 udf=1 sp=0", pc_out, udf, sp);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 2);
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if (udf !== 1'b1) begin bad++; $display("FAIL udf_sticky got=%b exp=1", udf); end
    step(1, 0, 0, 0, 0, 0, 0);
    total++; if (udf !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", udf); end
  endtask

  task automatic test_priority;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 9);
    step(0, 1, 1, 1, 0, 0, 3);
    total++; if (pc_out !== RV) begin bad++; $display("FAIL prio_clr got=%0d exp=%0d", pc_out, RV); end
    step(0, 0, 1, 1, 0, 0, 3);
    total++; if (pc_out !== 4'd3) begin bad++; $display("FAIL prio_ld got=%0d exp=3", pc_out); end
    step(0, 0, 0, 0, 1, 1, 10);
    total++; if (pc_out !== 4'd10 || sp !== 1 || udf !== 1'b0) begin
      bad++; $display("FAIL prio_call got pc=%0d sp=%0d udf=%b exp pc=10 sp=1 udf=0", pc_out, sp, udf);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    total++; if (pc_out !== RV || sp !== 1) begin
      bad++; $display("FAIL clr_keeps_stack got pc=%0d sp=%0d exp pc=%0d sp=1", pc_out, sp, RV);
    end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 4);
    step(0, 0, 0, 0, 1, 0, 8);
    step(1, 0, 0, 1, 0, 0, 0);
    total++; if (pc_out !== RV || sp !== 0 || {wrap, ovf, udf} !== 3'b000 || empty !== 1'b1) begin
      bad++; $display("FAIL rst_mid got pc=%0d sp=%0d wou=%b empty=%b exp pc=%0d sp=0 wou=000 empty=1",
                      pc_out, sp, {wrap, ovf, udf}, empty, RV);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if (udf !== 1'b1 || pc_out !== RV) begin
      bad++; $display("FAIL rst_mid_ret got udf=%b pc=%0d exp udf=1 pc=%0d", udf, pc_out, RV);
    end
  endtask

  task automatic test_random;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
           $urandom_range(0, MODV - 1));
      total++;
      if (pc_out !== ADDR_W'(m_pc) || sp !== m_stk.size() || wrap !== m_wrap || ovf !== m_ovf ||
          udf !== m_udf || full !== (m_stk.size() == DEPTH) || empty !== (m_stk.size() == 0)) begin
        bad++;
        $display("FAIL rand[%0d] got pc=%0d sp=%0d w=%b o=%b u=%b f=%b e=%b exp pc=%0d sp=%0d w=%b o=%b u=%b",
                 n, pc_out, sp, wrap, ovf, udf, full, empty, m_pc, m_stk.size(), m_wrap, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    rst = 1; clr = 0; ld = 0; inr = 0; call = 0; ret = 0; pc_in = '0;
    @(negedge clk);
    test_reset();
    test_inr_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
